dma_channel_arbiter: RTL and testbench

DMA_CHANNEL_ARBITER -- requirements
Module: dma_channel_arbiter

---
 rtl/dma_pkg.sv | 12 +
 rtl/dma_prio_encoder.sv | 33 +++
 rtl/dma_channel_arbiter.sv | 123 ++++++++++++
 tb/tb_dma_channel_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and sizing for the DMA channel arbiter.
package dma_pkg;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;
endpackage

// File: rtl/dma_prio_encoder.sv
// Fixed or rotating priority pick over the effective request vector.
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] r,
  input  logic [CH_W-1:0]   last,
  input  logic              rotate,
  output logic [CH_W-1:0]   winner,
  output logic              any
);

  logic [CH_W-1:0] w_base;
  logic [CH_W-1:0] w_idx;
  logic            w_found;

  // Scan starts at the channel after the last one served; index wraps mod NUM_CH.
  always_comb begin
    w_base  = rotate ? (last + CH_W'(1)) : '0;
    winner  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = w_base + CH_W'(i);
      if (!w_found && r[w_idx]) begin
        winner  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any = |r;

endmodule

// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA arbiter: picks a requester, negotiates the bus with the CPU
// via hrq/hlda, and holds the grant until the transfer sequencer finishes.
module dma_channel_arbiter
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] dreq,
  input  logic [NUM_CH-1:0] mask,
  input  logic [NUM_CH-1:0] sw_req,
  input  logic              dreq_low,
  input  logic              dack_high,
  input  logic              prio_rotate,
  input  logic              block_mode,
  input  logic              hlda,
  input  logic              xfer_done,
  input  logic              eop,
  output logic              hrq,
  output logic              grant_valid,
  output logic [CH_W-1:0]   grant_ch,
  output logic [NUM_CH-1:0] dack,
  output logic [NUM_CH-1:0] sw_req_clr,
  output logic              abort
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CH_W-1:0]     r_ch;
  logic [CH_W-1:0]     w_ch_nxt;
  logic [CH_W-1:0]     r_last;
  logic [CH_W-1:0]     w_last_nxt;
  logic [NUM_CH-1:0]   r_sw_clr;
  logic [NUM_CH-1:0]   w_sw_clr_nxt;
  logic                r_abort;
  logic                w_abort_nxt;
  logic [NUM_CH-1:0]   w_req;
  logic [CH_W-1:0]     w_winner;
  logic                w_any;

  // Software requests bypass both the mask and the DREQ polarity.
  assign w_req = ((dreq ^ {NUM_CH{dreq_low}}) & ~mask) | sw_req;

  dma_prio_encoder u_prio (
    .r      (w_req),
    .last   (r_last),
    .rotate (prio_rotate),
    .winner (w_winner),
    .any    (w_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ch     <= '0;
      r_last   <= CH_W'(NUM_CH - 1);
      r_sw_clr <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch     <= w_ch_nxt;
      r_last   <= w_last_nxt;
      r_sw_clr <= w_sw_clr_nxt;
      r_abort  <= w_abort_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ch_nxt     = r_ch;
    w_last_nxt   = r_last;
    w_sw_clr_nxt = '0;
    w_abort_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_ch_nxt    = w_winner;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (hlda)
          w_state_nxt = ST_GRANT;
        else if (!w_req[r_ch])
          w_state_nxt = ST_IDLE;
      end
      // The granted channel is locked in; request changes here are ignored.
      ST_GRANT: begin
        if (xfer_done) begin
          if (eop && sw_req[r_ch])
            w_sw_clr_nxt[r_ch] = 1'b1;
          if (!(block_mode && !eop && w_req[r_ch])) begin
            w_state_nxt = ST_RELEASE;
            w_last_nxt  = r_ch;
          end
        end else if (!hlda) begin
          w_abort_nxt = 1'b1;
          w_last_nxt  = r_ch;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        if (!hlda)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign hrq         = (r_state == ST_REQ) || (r_state == ST_GRANT);
  assign grant_valid = (r_state == ST_GRANT);
  assign grant_ch    = r_ch;
  assign sw_req_clr  = r_sw_clr;
  assign abort       = r_abort;

  always_comb begin
    dack = {NUM_CH{~dack_high}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_valid && (r_ch == CH_W'(i)))
        dack[i] = dack_high;
    end
  end

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for the DMA channel arbiter.
module tb_dma_channel_arbiter;
  logic       clk;
  logic       reset;
  logic [3:0] dreq, mask, sw_req;
  logic       dreq_low, dack_high, prio_rotate, block_mode;
  logic       hlda, xfer_done, eop;
  logic       hrq, grant_valid, abort;
  logic [1:0] grant_ch;
  logic [3:0] dack, sw_req_clr;

  int total = 0;
  int bad   = 0;

  dma_channel_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .dreq        (dreq),
    .mask        (mask),
    .sw_req      (sw_req),
    .dreq_low    (dreq_low),
    .dack_high   (dack_high),
    .prio_rotate (prio_rotate),
    .block_mode  (block_mode),
    .hlda        (hlda),
    .xfer_done   (xfer_done),
    .eop         (eop),
    .hrq         (hrq),
    .grant_valid (grant_valid),
    .grant_ch    (grant_ch),
    .dack        (dack),
    .sw_req_clr  (sw_req_clr),
    .abort       (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; dreq = '0; mask = '0; sw_req = '0;
    dreq_low = 1'b0; dack_high = 1'b0; prio_rotate = 1'b0; block_mode = 1'b0;
    hlda = 1'b0; xfer_done = 1'b0; eop = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (hrq !== 1'b0) begin bad++; $display("FAIL reset_hrq: got %b want 0", hrq); end
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
    total++; if (grant_ch !== 2'd0) begin bad++; $display("FAIL reset_ch: got %0d want 0", grant_ch); end
    total++; if (sw_req_clr !== 4'b0000 || abort !== 1'b0) begin bad++; $display("FAIL reset_pulses: got clr=%b abort=%b want 0000/0", sw_req_clr, abort); end
    total++; if (dack !== 4'b1111) begin bad++; $display("FAIL reset_dack_lo: got %b want 1111", dack); end
    dack_high = 1'b1; #1;
    total++; if (dack !== 4'b0000) begin bad++; $display("FAIL reset_dack_hi: got %b want 0000", dack); end
    dack_high = 1'b0;
  endtask

  task automatic test_fixed_prio();
    do_reset();
    dreq = 4'b0110; #1;
    total++; if (hrq !== 1'b0) begin bad++; $display("FAIL fixed_hrq_early: got %b want 0", hrq); end
    step();
    total++; if (hrq !== 1'b1 || grant_valid !== 1'b0) begin bad++; $display("FAIL fixed_req: got hrq=%b gv=%b want 1/0", hrq, grant_valid); end
    hlda = 1'b1;
    step();
    total++; if (grant_valid !== 1'b1 || grant_ch !== 2'd1) begin bad++; $display("FAIL fixed_grant: got gv=%b ch=%0d want 1/1", grant_valid, grant_ch); end
    total++; if (dack !== 4'b1101 || hrq !== 1'b1) begin bad++; $display("FAIL fixed_dack: got dack=%b hrq=%b want 1101/1", dack, hrq); end
    xfer_done = 1'b1; eop = 1'b1;
    step();
    xfer_done = 1'b0; eop = 1'b0; dreq = '0;
    total++; if (hrq !== 1'b0 || grant_valid !== 1'b0 || dack !== 4'b1111) begin bad++; $display("FAIL fixed_release: got hrq=%b gv=%b dack=%b want 0/0/1111", hrq, grant_valid, dack); end
    hlda = 1'b0;
    step(); step();
    total++; if (hrq !== 1'b0) begin bad++; $display("FAIL fixed_idle: got hrq=%b want 0", hrq); end
  endtask

  task automatic test_dreq_polarity();
    do_reset();
    dreq_low = 1'b1; dreq = 4'b1011;
    step();
    hlda = 1'b1;
    step();
    total++; if (grant_ch !== 2'd2 || dack !== 4'b1011) begin bad++; $display("FAIL polarity_grant: got ch=%0d dack=%b want 2/1011", grant_ch, dack); end
    dreq = 4'b1111; hlda = 1'b0; xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    step();
  endtask

  task automatic test_rotating();
    do_reset();
    prio_rotate = 1'b1; dreq = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      hlda = 1'b1;
      step();
      total++; if (grant_valid !== 1'b1 || grant_ch !== 2'(k)) begin bad++; $display("FAIL rotate_order%0d: got gv=%b ch=%0d want 1/%0d", k, grant_valid, grant_ch, k); end
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0; hlda = 1'b0;
      step();
    end
    dreq = '0;
    step();
  endtask

  task automatic test_block_mode();
    do_reset();
    block_mode = 1'b1; dreq = 4'b0100;
    step();
    hlda = 1'b1;
    step();
    total++; if (grant_valid !== 1'b1 || grant_ch !== 2'd2) begin bad++; $display("FAIL block_grant: got gv=%b ch=%0d want 1/2", grant_valid, grant_ch); end
    for (int i = 0; i < 3; i++) begin
      xfer_done = 1'b1; eop = (i == 2);
      step();
      xfer_done = 1'b0; eop = 1'b0;
      if (i < 2) begin
        total++; if (grant_valid !== 1'b1 || grant_ch !== 2'd2 || hrq !== 1'b1) begin bad++; $display("FAIL block_hold%0d: got gv=%b ch=%0d hrq=%b want 1/2/1", i, grant_valid, grant_ch, hrq); end
        step();
      end else begin
        total++; if (grant_valid !== 1'b0 || hrq !== 1'b0 || dack !== 4'b1111) begin bad++; $display("FAIL block_release: got gv=%b hrq=%b dack=%b want 0/0/1111", grant_valid, hrq, dack); end
      end
    end
    dreq = '0; hlda = 1'b0;
    step();
  endtask

  task automatic test_dropped();
    do_reset();
    dreq = 4'b1000;
    step();
    total++; if (hrq !== 1'b1) begin bad++; $display("FAIL drop_req: got hrq=%b want 1", hrq); end
    dreq = 4'b0000;
    step();
    total++; if (hrq !== 1'b0 || grant_valid !== 1'b0 || dack !== 4'b1111) begin bad++; $display("FAIL drop_idle: got hrq=%b gv=%b dack=%b want 0/0/1111", hrq, grant_valid, dack); end
    hlda = 1'b1;
    step();
    total++; if (grant_valid !== 1'b0 || dack !== 4'b1111) begin bad++; $display("FAIL drop_nodack: got gv=%b dack=%b want 0/1111", grant_valid, dack); end
    hlda = 1'b0;
  endtask

  task automatic test_sw_req();
    do_reset();
    mask = 4'b1111; dreq = 4'b1111; sw_req = 4'b0001;
    step();
    hlda = 1'b1;
    step();
    total++; if (grant_valid !== 1'b1 || grant_ch !== 2'd0 || dack !== 4'b1110) begin bad++; $display("FAIL sw_grant: got gv=%b ch=%0d dack=%b want 1/0/1110", grant_valid, grant_ch, dack); end
    xfer_done = 1'b1; eop = 1'b1;
    step();
    xfer_done = 1'b0; eop = 1'b0;
    total++; if (sw_req_clr !== 4'b0001) begin bad++; $display("FAIL sw_clr_pulse: got %b want 0001", sw_req_clr); end
    sw_req = 4'b0000; hlda = 1'b0;
    step();
    total++; if (sw_req_clr !== 4'b0000) begin bad++; $display("FAIL sw_clr_end: got %b want 0000", sw_req_clr); end
    mask = '0; dreq = '0;
  endtask

  task automatic test_reset_and_abort();
    do_reset();
    dreq = 4'b0001;
    step();
    hlda = 1'b1;
    step();
    total++; if (dack !== 4'b1110) begin bad++; $display("FAIL midrst_grant: got dack=%b want 1110", dack); end
    reset = 1'b1;
    step();
    total++; if (hrq !== 1'b0 || dack !== 4'b1111 || grant_valid !== 1'b0) begin bad++; $display("FAIL midrst_release: got hrq=%b dack=%b gv=%b want 0/1111/0", hrq, dack, grant_valid); end
    reset = 1'b0; hlda = 1'b0; dreq = 4'b0010;
    step();
    hlda = 1'b1;
    step();
    total++; if (grant_valid !== 1'b1 || grant_ch !== 2'd1) begin bad++; $display("FAIL abort_grant: got gv=%b ch=%0d want 1/1", grant_valid, grant_ch); end
    hlda = 1'b0;
    step();
    dreq = '0;
    total++; if (abort !== 1'b1 || hrq !== 1'b0 || grant_valid !== 1'b0 || dack !== 4'b1111) begin bad++; $display("FAIL abort_pulse: got abort=%b hrq=%b gv=%b dack=%b want 1/0/0/1111", abort, hrq, grant_valid, dack); end
    step();
    total++; if (abort !== 1'b0 || hrq !== 1'b0) begin bad++; $display("FAIL abort_end: got abort=%b hrq=%b want 0/0", abort, hrq); end
  endtask

  initial begin
    test_reset();
    test_fixed_prio();
    test_dreq_polarity();
    test_rotating();
    test_block_mode();
    test_dropped();
    test_sw_req();
    test_reset_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
